// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: direction encodings, valid-move bit positions and maze geometry.
// Used by pacman_move_ctrl, collision_detect and the ghost controllers.
package pacman_pkg;

    localparam int MAZE_W = 28;
    localparam int X_W    = 6;
    localparam int Y_W    = 5;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Bit positions in pacman_valid_moves and joy, both packed {up,down,left,right}
    localparam int VM_UP    = 3;
    localparam int VM_DOWN  = 2;
    localparam int VM_LEFT  = 1;
    localparam int VM_RIGHT = 0;

    function automatic logic [1:0] vm_index(input dir_t d);
        logic [1:0] idx;
        case (d)
            DIR_UP:   idx = 2'(VM_UP);
            DIR_DOWN: idx = 2'(VM_DOWN);
            DIR_LEFT: idx = 2'(VM_LEFT);
            default:  idx = 2'(VM_RIGHT);
        endcase
        return idx;
    endfunction

    // Highest-priority pressed direction, up > down > left > right
    function automatic dir_t joy_to_dir(input logic [3:0] joy);
        dir_t d;
        if (joy[VM_UP])
            d = DIR_UP;
        else if (joy[VM_DOWN])
            d = DIR_DOWN;
        else if (joy[VM_LEFT])
            d = DIR_LEFT;
        else
            d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Movement tick divider: counts 0..TICK_DIV-1 while enabled, tick marks the last count.
// Shared by the Pac-Man and ghost movers; clr restarts the period.
module move_tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk_100mhz,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TC);

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == TC) ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/pacman_move_ctrl.sv
// Pac-Man movement controller: latches joystick requests, decides turn/continue/stop each tick,
// steps one tile, then waits for collision_detect to settle. Optional PACMAN_TUNNEL_WRAP_EN wraps x.
//
// state     | meaning
// WAIT_TICK | waiting for the movement tick (counter runs while run=1)
// DECIDE    | sample pacman_valid_moves, pick turn / continue / stop
// MOVE      | step one tile in cur_dir, moved=1
// SETTLE    | give collision_detect SETTLE_CYC cycles to recompute
module pacman_move_ctrl
    import pacman_pkg::*;
#(
    parameter int TICK_DIV   = 12500000,
    parameter int SETTLE_CYC = 8,
    parameter int START_X    = 13,
    parameter int START_Y    = 23
) (
    input  logic           clk_100mhz,
    input  logic           rst_n,
    input  logic           run,
    input  logic           restart,
    input  logic [3:0]     joy,
    input  logic [3:0]     pacman_valid_moves,
    output logic [X_W-1:0] pacman_x,
    output logic [Y_W-1:0] pacman_y,
    output logic [1:0]     cur_dir,
    output logic           moving,
    output logic           moved
);

    typedef enum logic [1:0] {
        ST_WAIT_TICK,
        ST_DECIDE,
        ST_MOVE,
        ST_SETTLE
    } move_state_t;

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [X_W-1:0] X_START = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
    localparam logic [X_W-1:0] X_LAST  = X_W'(MAZE_W - 1);

    move_state_t    state, state_nxt;
    dir_t           dir_q, dir_nxt;
    dir_t           req_dir_q, req_dir_nxt;
    logic           req_pend_q, req_pend_nxt;
    logic           moving_q, moving_nxt;
    logic [X_W-1:0] x_q, x_nxt;
    logic [Y_W-1:0] y_q, y_nxt;
    logic [SCW-1:0] settle_q, settle_nxt;
    logic           tick;

    move_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk_100mhz(clk_100mhz),
        .rst_n     (rst_n),
        .en        (run && (state == ST_WAIT_TICK)),
        .clr       (restart),
        .tick      (tick)
    );

    function automatic logic dir_open(input dir_t d, input logic [3:0] vm, input logic [X_W-1:0] x);
        logic ok;
        ok = vm[vm_index(d)];
`ifdef PACMAN_TUNNEL_WRAP_EN
        // Edge columns are tunnels: trust collision_detect there too
`else
        if ((d == DIR_LEFT && x == '0) || (d == DIR_RIGHT && x == X_LAST))
            ok = 1'b0;
`endif
        return ok;
    endfunction

    always_comb begin
        state_nxt    = state;
        dir_nxt      = dir_q;
        req_dir_nxt  = req_dir_q;
        req_pend_nxt = req_pend_q;
        moving_nxt   = moving_q;
        x_nxt        = x_q;
        y_nxt        = y_q;
        settle_nxt   = settle_q;

        case (state)
            ST_WAIT_TICK: begin
                if (tick)
                    state_nxt = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (req_pend_q && dir_open(req_dir_q, pacman_valid_moves, x_q)) begin
                    dir_nxt      = req_dir_q;
                    req_pend_nxt = 1'b0;
                    moving_nxt   = 1'b1;
                    state_nxt    = ST_MOVE;
                end else if (moving_q && dir_open(dir_q, pacman_valid_moves, x_q)) begin
                    state_nxt = ST_MOVE;
                end else begin
                    moving_nxt = 1'b0;
                    state_nxt  = ST_WAIT_TICK;
                end
            end
            ST_MOVE: begin
                case (dir_q)
                    DIR_UP:   y_nxt = y_q - Y_W'(1);
                    DIR_DOWN: y_nxt = y_q + Y_W'(1);
                    DIR_LEFT: begin
`ifdef PACMAN_TUNNEL_WRAP_EN
                        x_nxt = (x_q == '0) ? X_LAST : x_q - X_W'(1);
`else
                        x_nxt = x_q - X_W'(1);
`endif
                    end
                    default: begin
`ifdef PACMAN_TUNNEL_WRAP_EN
                        x_nxt = (x_q == X_LAST) ? '0 : x_q + X_W'(1);
`else
                        x_nxt = x_q + X_W'(1);
`endif
                    end
                endcase
                settle_nxt = SCW'(SETTLE_CYC - 1);
                state_nxt  = ST_SETTLE;
            end
            default: begin
                if (run) begin
                    if (settle_q == '0)
                        state_nxt = ST_WAIT_TICK;
                    else
                        settle_nxt = settle_q - SCW'(1);
                end
            end
        endcase

        // A press in the DECIDE cycle wins over the consume, so the newest request survives
        if (joy != 4'b0000) begin
            req_dir_nxt  = joy_to_dir(joy);
            req_pend_nxt = 1'b1;
        end

        if (restart) begin
            state_nxt    = ST_WAIT_TICK;
            dir_nxt      = DIR_LEFT;
            req_dir_nxt  = DIR_UP;
            req_pend_nxt = 1'b0;
            moving_nxt   = 1'b0;
            x_nxt        = X_START;
            y_nxt        = Y_START;
            settle_nxt   = '0;
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_WAIT_TICK;
            dir_q      <= DIR_LEFT;
            req_dir_q  <= DIR_UP;
            req_pend_q <= 1'b0;
            moving_q   <= 1'b0;
            x_q        <= X_START;
            y_q        <= Y_START;
            settle_q   <= '0;
        end else begin
            state      <= state_nxt;
            dir_q      <= dir_nxt;
            req_dir_q  <= req_dir_nxt;
            req_pend_q <= req_pend_nxt;
            moving_q   <= moving_nxt;
            x_q        <= x_nxt;
            y_q        <= y_nxt;
            settle_q   <= settle_nxt;
        end
    end

    assign pacman_x = x_q;
    assign pacman_y = y_q;
    assign cur_dir  = dir_q;
    assign moving   = moving_q;
    assign moved    = (state == ST_MOVE);

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Bench for pacman_move_ctrl: directed scenarios with literal expectations, then random stimulus
// checked every cycle against a timeline model. Honours PACMAN_TUNNEL_WRAP_EN like the DUT.
module tb_pacman_move_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int SETTLE_CYC = 4;
    localparam int MAZE_W     = 28;
`ifdef PACMAN_TUNNEL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk_100mhz = 1'b0;
    logic       rst_n;
    logic       run;
    logic       restart;
    logic [3:0] joy;
    logic [3:0] valid;
    logic [5:0] pacman_x;
    logic [4:0] pacman_y;
    logic [1:0] cur_dir;
    logic       moving;
    logic       moved;

    int checks = 0;
    int errors = 0;
    int moved_cnt = 0;

    pacman_move_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .SETTLE_CYC(SETTLE_CYC),
        .START_X   (13),
        .START_Y   (23)
    ) dut (
        .clk_100mhz        (clk_100mhz),
        .rst_n             (rst_n),
        .run               (run),
        .restart           (restart),
        .joy               (joy),
        .pacman_valid_moves(valid),
        .pacman_x          (pacman_x),
        .pacman_y          (pacman_y),
        .cur_dir           (cur_dir),
        .moving            (moving),
        .moved             (moved)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Timeline model: where in the tick / decide / step / settle cycle Pac-Man is, as plain counters
    int m_x, m_y, m_dir, m_moving;
    int rq_dir, rq_pend;
    int wait_cnt, settle_left;
    bit decide_now, step_now;

    task automatic model_reset();
        m_x = 13; m_y = 23; m_dir = 2; m_moving = 0;
        rq_dir = 0; rq_pend = 0;
        wait_cnt = 0; settle_left = 0;
        decide_now = 1'b0; step_now = 1'b0;
    endtask

    function automatic int pick_dir(input logic [3:0] j);
        if (j[3]) return 0;
        if (j[2]) return 1;
        if (j[1]) return 2;
        return 3;
    endfunction

    function automatic bit is_open(input int d, input logic [3:0] vm, input int x);
        logic [3:0] v;
        v = vm;
        if (!WRAP && d == 2 && x == 0) return 1'b0;
        if (!WRAP && d == 3 && x == MAZE_W - 1) return 1'b0;
        return v[3 - d];
    endfunction

    task automatic model_step();
        if (restart) begin
            model_reset();
        end else begin
            if (decide_now) begin
                decide_now = 1'b0;
                if (rq_pend != 0 && is_open(rq_dir, valid, m_x)) begin
                    m_dir = rq_dir; rq_pend = 0; m_moving = 1; step_now = 1'b1;
                end else if (m_moving != 0 && is_open(m_dir, valid, m_x)) begin
                    step_now = 1'b1;
                end else begin
                    m_moving = 0;
                end
            end else if (step_now) begin
                step_now = 1'b0;
                case (m_dir)
                    0: m_y = (m_y + 31) % 32;
                    1: m_y = (m_y + 1) % 32;
                    2: m_x = (WRAP && m_x == 0) ? MAZE_W - 1 : (m_x + 63) % 64;
                    default: m_x = (WRAP && m_x == MAZE_W - 1) ? 0 : (m_x + 1) % 64;
                endcase
                settle_left = SETTLE_CYC;
            end else if (settle_left > 0) begin
                if (run) settle_left--;
            end else if (run) begin
                if (wait_cnt == TICK_DIV - 1) begin
                    wait_cnt = 0; decide_now = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
            if (joy != 4'b0000) begin
                rq_dir = pick_dir(joy); rq_pend = 1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_100mhz or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk_100mhz);
            if (rst_n === 1'b1) begin
                if (moved === 1'b1) moved_cnt++;
                check("model_x", int'(pacman_x), m_x);
                check("model_y", int'(pacman_y), m_y);
                check("model_dir", int'(cur_dir), m_dir);
                check("model_moving", int'(moving), m_moving);
                check("model_moved", int'(moved), int'(step_now));
            end
        end
    end

    task automatic wait_moved(input int budget);
        int n;
        n = 0;
        @(negedge clk_100mhz);
        while (moved !== 1'b1 && n < budget) begin
            @(negedge clk_100mhz);
            n++;
        end
        if (moved !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_moved_timeout actual=no_pulse required=pulse within %0d cycles", budget);
        end
    endtask

    task automatic press(input logic [3:0] j, input logic [3:0] vm);
        joy = j;
        valid = vm;
        @(negedge clk_100mhz);
        joy = 4'b0000;
    endtask

    initial begin
        int mc;
        rst_n = 1'b0; run = 1'b0; restart = 1'b0; joy = 4'b0000; valid = 4'b0011;
        repeat (3) @(negedge clk_100mhz);
        rst_n = 1'b1;
        check("rst_x", int'(pacman_x), 13);
        check("rst_y", int'(pacman_y), 23);
        check("rst_dir", int'(cur_dir), 2);
        check("rst_moving", int'(moving), 0);
        check("rst_moved", int'(moved), 0);

        // Idle: no request, nothing moves
        run = 1'b1;
        repeat (20) @(negedge clk_100mhz);
        check("idle_x", int'(pacman_x), 13);
        check("idle_moving", int'(moving), 0);
        check("idle_no_moved", moved_cnt, 0);

        // Start moving left
        press(4'b0010, 4'b0010);
        wait_moved(40);
        check("left_dir", int'(cur_dir), 2);
        check("left_moving", int'(moving), 1);
        @(negedge clk_100mhz);
        check("left_x1", int'(pacman_x), 12);
        wait_moved(40);
        @(negedge clk_100mhz);
        check("left_x2", int'(pacman_x), 11);

        // Up request while up is closed: keep going left, then turn when up opens
        press(4'b1000, 4'b0010);
        wait_moved(40);
        @(negedge clk_100mhz);
        check("pend_x", int'(pacman_x), 10);
        check("pend_dir", int'(cur_dir), 2);
        valid = 4'b1010;
        wait_moved(40);
        @(negedge clk_100mhz);
        check("turn_dir", int'(cur_dir), 0);
        check("turn_y", int'(pacman_y), 22);
        check("turn_x", int'(pacman_x), 10);

        // Turn right, then run into a wall
        press(4'b0001, 4'b0001);
        wait_moved(40);
        @(negedge clk_100mhz);
        check("right_dir", int'(cur_dir), 3);
        check("right_x", int'(pacman_x), 11);
        valid = 4'b0000;
        repeat (20) @(negedge clk_100mhz);
        check("wall_moving", int'(moving), 0);
        check("wall_x", int'(pacman_x), 11);
        check("wall_y", int'(pacman_y), 22);

        // Walk left to the tunnel column
        press(4'b0010, 4'b0010);
        repeat (11) wait_moved(40);
        @(negedge clk_100mhz);
        check("edge_x", int'(pacman_x), 0);
`ifdef PACMAN_TUNNEL_WRAP_EN
        wait_moved(40);
        @(negedge clk_100mhz);
        check("wrap_x", int'(pacman_x), 27);
`else
        repeat (20) @(negedge clk_100mhz);
        check("edge_moving", int'(moving), 0);
        check("edge_hold_x", int'(pacman_x), 0);
`endif

        // Restart with a simultaneous press: request must be dropped
        restart = 1'b1; joy = 4'b1000;
        @(negedge clk_100mhz);
        restart = 1'b0; joy = 4'b0000;
        check("restart_x", int'(pacman_x), 13);
        check("restart_y", int'(pacman_y), 23);
        check("restart_dir", int'(cur_dir), 2);
        valid = 4'b1111;
        repeat (20) @(negedge clk_100mhz);
        check("restart_no_req", int'(moving), 0);

        // Freeze mid-settle
        press(4'b0010, 4'b0010);
        wait_moved(40);
        @(negedge clk_100mhz);
        run = 1'b0;
        mc = moved_cnt;
        repeat (30) @(negedge clk_100mhz);
        check("freeze_moved", moved_cnt, mc);
        check("freeze_x", int'(pacman_x), 12);
        run = 1'b1;
        wait_moved(40);

        // Asynchronous reset while in MOVE
        wait_moved(40);
        #1 rst_n = 1'b0;
        #1;
        check("arst_x", int'(pacman_x), 13);
        check("arst_y", int'(pacman_y), 23);
        check("arst_dir", int'(cur_dir), 2);
        check("arst_moving", int'(moving), 0);
        check("arst_moved", int'(moved), 0);
        @(negedge clk_100mhz);
        rst_n = 1'b1;

        // Random play against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_100mhz);
            joy = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            if ($urandom_range(0, 15) == 0) valid = 4'($urandom_range(0, 15));
            run = ($urandom_range(0, 19) != 0);
            restart = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk_100mhz);
        joy = 4'b0000; restart = 1'b0;
        @(negedge clk_100mhz);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pacman_move_ctrl.md
Name: pacman_move_ctrl

Overview:
- Consumes pacman_valid_moves from collision_detect and owns the Pac-Man tile position (pacman_x, pacman_y) that collision_detect reads back.
- Latches the player's joystick request and decides each movement tick whether to turn, continue or stop.
- Advances the position one tile per tick, then waits for collision_detect to settle before the next decision.

Parameters:
- TICK_DIV, 12500000: clk_100mhz cycles per movement tick (8 tiles/s).
- SETTLE_CYC, 8: cycles to wait after a move so collision_detect recomputes valid moves (at least 2 full phase rotations).
- MAZE_W, 28: maze width in tiles; x range 0..MAZE_W-1.
- START_X, 13: x position loaded on reset/restart.
- START_Y, 23: y position loaded on reset/restart.

Ports:
- clk_100mhz  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  game running; 0 freezes the block
- restart  in  1  synchronous pulse: reload start position, clear direction and request
- joy  in  4  joystick level {up,down,left,right}
- pacman_valid_moves  in  4  from collision_detect, {up,down,left,right}, 1 = open
- pacman_x  out  6  tile x
- pacman_y  out  5  tile y
- cur_dir  out  2  0 up, 1 down, 2 left, 3 right
- moving  out  1  cur_dir is active
- moved  out  1  one-cycle pulse on each position update

Behaviour:
- Reset (async, rst_n=0) sets:
  - pacman_x=START_X, pacman_y=START_Y
  - cur_dir=2, moving=0, moved=0
  - request cleared, tick counter 0, state WAIT_TICK
- Request latch, every cycle:
  - If any joy bit is set, latch the highest-priority bit (up>down>left>right) as req_dir and set req_pend=1.
  - A new press overwrites a pending request.
  - joy=0 leaves the request unchanged.
- Tick counter:
  - Counts 0..TICK_DIV-1 only in WAIT_TICK with run=1.
  - Held when run=0.
  - Reaching TICK_DIV-1 moves the FSM to DECIDE and resets the counter to 0.
- FSM:
  - WAIT_TICK: as above.
  - DECIDE, one cycle, samples pacman_valid_moves:
    - If req_pend and the bit for req_dir is set: cur_dir=req_dir, req_pend=0, moving=1, go to MOVE.
    - Else if moving and the bit for cur_dir is set: go to MOVE.
    - Else: moving=0, keep req_pend, go to WAIT_TICK.
  - MOVE, one cycle:
    - up: y-1; down: y+1; left: x-1; right: x+1.
    - moved=1 for exactly this cycle.
    - Go to SETTLE.
  - SETTLE: count SETTLE_CYC cycles, then go to WAIT_TICK. The counter is held while run=0.
- Edge handling:
  - Boundary handling for x=0 left and x=MAZE_W-1 right: see Optional Feature.
  - y is not range-checked; collision_detect guarantees the maze border blocks it.
- Move latency: tick to position update is 2 cycles (DECIDE, MOVE).
- restart: has priority over all FSM activity. Next cycle state = reset values except rst_n-dependent nothing. A restart coinciding with joy leaves the request cleared.
- run=0 mid-SETTLE or mid-WAIT_TICK: counters freeze. DECIDE and MOVE always complete once entered.

Optional Feature:
- Macro: PACMAN_TUNNEL_WRAP_EN.
- Defined:
  - Left at x=0 with left valid: x becomes MAZE_W-1.
  - Right at x=MAZE_W-1 with right valid: x becomes 0.
- Undefined:
  - Left at x=0 or right at x=MAZE_W-1 is treated as blocked in DECIDE, regardless of pacman_valid_moves (moving=0).

Decomposition:
- Shared package pacman_pkg holds:
  - Direction encodings DIR_UP/DOWN/LEFT/RIGHT.
  - The valid-moves bit indices.
  - MAZE_W and the coordinate widths (6/5). These are shared with collision_detect and the ghost controllers.
- One natural sub-module: move_tick_gen (TICK_DIV counter with run enable and clear). Ghost movers will reuse it.

Test Plan (TICK_DIV=4, SETTLE_CYC=4):
- Reset then run=1, valid=4'b0011, no joy:
  - moving stays 0, position stays (13,23), and moved never pulses.
- joy=4'b0010 held 1 cycle, valid=4'b0010:
  - At the next tick, cur_dir=2 and moving=1.
  - moved pulses and x becomes 12.
  - After SETTLE + next tick, x becomes 11.
- Moving left, then joy=up pulse with valid=4'b0010:
  - Left continues and req_pend stays set.
  - When valid changes to 4'b1010, the next DECIDE sets cur_dir=0 and y becomes 22.
- Moving right into valid=4'b0000:
  - moving drops to 0 and position is unchanged.
- Tunnel: x=0, moving left, valid=4'b0010:
  - With PACMAN_TUNNEL_WRAP_EN, x becomes 27.
  - Without it, moving becomes 0 and x stays 0.
- Freeze and reset:
  - run=0 mid-SETTLE: no moved pulse until run=1.
  - rst_n low while in MOVE: outputs return immediately (async) to (13,23), cur_dir=2, moving=0.
